// File: rtl/alu_muldiv_seq.sv
// Sequential multiply/divide unit: one bit per clock, double-width product or quotient/remainder.
// Define ALU_MULDIV_SIGNED_EN to enable the signed ops (muls/divs); otherwise ctl[0] is ignored.
module alu_muldiv_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       ctl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] S,
    output logic             exception
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned AW = 2 * WIDTH;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

`ifdef ALU_MULDIV_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PREP = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [1:0] FIX  = 2'd3;

    logic [1:0]       state, state_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [WIDTH-1:0] a_reg, a_reg_nx;
    logic [WIDTH-1:0] b_reg, b_reg_nx;
    logic             is_div, is_div_nx;
    logic             is_signed, is_signed_nx;
    logic [WIDTH-1:0] opnd, opnd_nx;
    logic [AW-1:0]    acc, acc_nx;
    logic [WIDTH-1:0] rem, rem_nx;
    logic             neg_q, neg_q_nx;
    logic             neg_r, neg_r_nx;
    logic             ovf, ovf_nx;
    logic             busy_nx, done_nx, exception_nx;
    logic [WIDTH-1:0] r_nx, s_nx;

    // Single iteration datapath and final sign correction
    logic [WIDTH:0]   mul_sum;
    logic [AW-1:0]    mul_acc;
    logic [AW-1:0]    prod_fix;
    logic [WIDTH:0]   div_shift;
    logic             div_ok;
    logic [WIDTH-1:0] div_sub, div_rem, div_quo;
    logic [WIDTH-1:0] quo_fix, rem_fix;
    logic             neg_a, neg_b;
    logic [WIDTH-1:0] mag_a, mag_b;

    always_comb begin
        mul_sum   = {1'b0, acc[AW-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : (WIDTH+1)'(0));
        mul_acc   = {mul_sum, acc[WIDTH-1:1]};
        prod_fix  = neg_q ? -mul_acc : mul_acc;
        div_shift = {rem, acc[WIDTH-1]};
        div_ok    = (div_shift >= {1'b0, opnd});
        div_sub   = div_shift[WIDTH-1:0] - opnd;
        div_rem   = div_ok ? div_sub : div_shift[WIDTH-1:0];
        div_quo   = {acc[WIDTH-2:0], div_ok};
        quo_fix   = neg_q ? -div_quo : div_quo;
        rem_fix   = neg_r ? -div_rem : div_rem;
        neg_a     = is_signed & a_reg[WIDTH-1];
        neg_b     = is_signed & b_reg[WIDTH-1];
        mag_a     = neg_a ? -a_reg : a_reg;
        mag_b     = neg_b ? -b_reg : b_reg;
    end

    // Next-state and registered-output logic
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        a_reg_nx     = a_reg;
        b_reg_nx     = b_reg;
        is_div_nx    = is_div;
        is_signed_nx = is_signed;
        opnd_nx      = opnd;
        acc_nx       = acc;
        rem_nx       = rem;
        neg_q_nx     = neg_q;
        neg_r_nx     = neg_r;
        ovf_nx       = ovf;
        r_nx         = R;
        s_nx         = S;
        exception_nx = exception;

        case (state)
            IDLE: begin
                if (start) begin
                    a_reg_nx     = A;
                    b_reg_nx     = B;
                    is_div_nx    = ctl[1];
                    is_signed_nx = SIGNED_EN & ctl[0];
                    state_nx     = PREP;
                end
            end
            PREP: begin
                neg_q_nx = neg_a ^ neg_b;
                neg_r_nx = neg_a;
                ovf_nx   = is_signed & is_div & (a_reg == MIN_VAL) & (b_reg == '1);
                cnt_nx   = CW'(WIDTH - 1);
                rem_nx   = '0;
                state_nx = RUN;
                if (is_div) begin
                    opnd_nx = mag_b;
                    acc_nx  = {{WIDTH{1'b0}}, mag_a};
                    // Divide by zero bypasses iteration entirely
                    if (b_reg == '0) begin
                        state_nx     = FIX;
                        r_nx         = '1;
                        s_nx         = a_reg;
                        exception_nx = 1'b1;
                    end
                end else begin
                    opnd_nx = mag_a;
                    acc_nx  = {{WIDTH{1'b0}}, mag_b};
                end
            end
            RUN: begin
                cnt_nx = cnt - CW'(1);
                if (is_div) begin
                    acc_nx = {acc[AW-1:WIDTH], div_quo};
                    rem_nx = div_rem;
                end else begin
                    acc_nx = mul_acc;
                end
                // Results land on the edge into FIX so they are valid alongside done
                if (cnt == '0) begin
                    state_nx = FIX;
                    if (is_div) begin
                        r_nx         = quo_fix;
                        s_nx         = rem_fix;
                        exception_nx = ovf;
                    end else begin
                        r_nx         = prod_fix[WIDTH-1:0];
                        s_nx         = prod_fix[AW-1:WIDTH];
                        exception_nx = 1'b0;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        busy_nx = (state_nx != IDLE);
        done_nx = (state_nx == FIX);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            is_div    <= 1'b0;
            is_signed <= 1'b0;
            opnd      <= '0;
            acc       <= '0;
            rem       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            ovf       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            R         <= '0;
            S         <= '0;
            exception <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            a_reg     <= a_reg_nx;
            b_reg     <= b_reg_nx;
            is_div    <= is_div_nx;
            is_signed <= is_signed_nx;
            opnd      <= opnd_nx;
            acc       <= acc_nx;
            rem       <= rem_nx;
            neg_q     <= neg_q_nx;
            neg_r     <= neg_r_nx;
            ovf       <= ovf_nx;
            busy      <= busy_nx;
            done      <= done_nx;
            R         <= r_nx;
            S         <= s_nx;
            exception <= exception_nx;
        end
    end

endmodule
